// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: credit-limited sequential fetch into an in-order prefetch queue.
// Optional FETCH_PERF_CNT_EN adds flush/drop performance counters.
module fetch_prefetch_unit #(
  parameter int WORD_SIZE   = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0,
  parameter int PC_STEP     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jmp_ctrl_signal,
  input  logic [WORD_SIZE-1:0] jump_address,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [WORD_SIZE-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [WORD_SIZE-1:0] mem_rsp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] instruction_out,
  output logic [WORD_SIZE-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_flush_count,
  output logic [31:0]          perf_drop_count
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(PC_STEP);
  localparam logic [CW:0] DEPTH = (CW+1)'(QUEUE_DEPTH);

  logic [WORD_SIZE-1:0] ins_q [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] pcs_q [QUEUE_DEPTH];

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] rsp_pc_q, rsp_pc_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW-1:0]        wr_q, wr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [CW-1:0]        outst_rsp;

  logic credit_ok;
  logic req_fire;
  logic rsp_drop;
  logic push;
  logic pop;
  logic empty;

  always_comb begin
    credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH;
    mem_req_valid = !reset && !jmp_ctrl_signal && credit_ok;
    mem_req_addr = pc_q;
    req_fire = mem_req_valid && mem_req_ready;
    rsp_drop = mem_rsp_valid &&
               ((drop_q != '0) || jmp_ctrl_signal);
    push = mem_rsp_valid && !rsp_drop;
    empty = (count_q == '0);
    inst_valid = !empty && !jmp_ctrl_signal;
    pop = inst_valid && inst_ready;
    instruction_out = empty ? '0 : ins_q[rd_q];
    inst_pc = empty ? '0 : pcs_q[rd_q];
  end

  always_comb begin
    pc_d = pc_q;
    rsp_pc_d = rsp_pc_q;
    rd_d = rd_q;
    wr_d = wr_q;
    drop_d = drop_q;
    // A response with nothing tracked belongs to a pre-reset request.
    outst_rsp = outst_q;
    if (mem_rsp_valid && (outst_q != '0))
      outst_rsp = outst_q - CW'(1);
    outst_d = outst_rsp + CW'(req_fire);
    count_d = count_q + CW'(push) - CW'(pop);
    if (req_fire)
      pc_d = pc_q + STEP;
    if (push) begin
      rsp_pc_d = rsp_pc_q + STEP;
      wr_d = wr_q + AW'(1);
    end
    if (pop)
      rd_d = rd_q + AW'(1);
    if (mem_rsp_valid && (drop_q != '0))
      drop_d = drop_q - CW'(1);
    if (jmp_ctrl_signal) begin
      pc_d = jump_address;
      rsp_pc_d = jump_address;
      rd_d = '0;
      wr_d = '0;
      count_d = '0;
      drop_d = outst_rsp;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ins_q[wr_q] <= mem_rsp_data;
      pcs_q[wr_q] <= rsp_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_q;
  logic [31:0] dropc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_q <= '0;
      dropc_q <= '0;
    end else begin
      if (jmp_ctrl_signal && (flush_q != '1))
        flush_q <= flush_q + 32'd1;
      if (rsp_drop && (dropc_q != '1))
        dropc_q <= dropc_q + 32'd1;
    end
  end

  assign perf_flush_count = flush_q;
  assign perf_drop_count = dropc_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a fixed-latency memory model.
// Memory returns addr ^ 0xA5A5A5A5 for every accepted request.
module tb_fetch_prefetch_unit;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  typedef struct {
    int          due;
    logic [31:0] a;
  } pend_t;

  logic        clock;
  logic        reset;
  logic        jmp_ctrl_signal;
  logic [31:0] jump_address;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction_out;
  logic [31:0] inst_pc;

  fetch_prefetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .jmp_ctrl_signal (jmp_ctrl_signal),
    .jump_address    (jump_address),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction_out (instruction_out),
    .inst_pc         (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pend_t       pq[$];
  int          cyc;
  int          lat;
  int          nacc;
  int          npass;
  int          ntot;
  bit          rnd;
  logic        s_req_v;
  logic [31:0] s_req_a;
  logic        s_inst_v;
  logic [31:0] s_inst_pc;
  logic [31:0] s_inst;
  logic        s_rsp;
  logic        s_rdy;
  logic [31:0] last_a;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, o, e);
  endtask

  task automatic tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = pq[0].a ^ K;
      void'(pq.pop_front());
    end
    if (rnd) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
    end
    #1;
    s_req_v = mem_req_valid;
    s_req_a = mem_req_addr;
    s_inst_v = inst_valid;
    s_inst_pc = inst_pc;
    s_inst = instruction_out;
    s_rsp = mem_rsp_valid;
    s_rdy = inst_ready;
    if (mem_req_valid && mem_req_ready) begin
      pq.push_back('{due: cyc + lat, a: mem_req_addr});
      nacc++;
      last_a = mem_req_addr;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    jmp_ctrl_signal = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_req_ready = 1'b1;
    inst_ready = 1'b1;
    rnd = 1'b0;
    pq.delete();
    #1;
    chk("rst_req_v", 32'(mem_req_valid), 0);
    chk("rst_inst_v", 32'(inst_valid), 0);
    chk("rst_inst", instruction_out, 0);
    chk("rst_pc", inst_pc, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc = 1;
    nacc = 0;
  endtask

  int          tbc;
  int          maxc;
  logic [31:0] ex;

  initial begin
    npass = 0;
    ntot = 0;
    lat = 1;
    jump_address = '0;
    reset = 1'b1;
    @(negedge clock);

    // basic streaming, 1-cycle memory
    do_reset();
    tick();
    chk("t1_rv1", 32'(s_req_v), 1);
    chk("t1_ra1", s_req_a, 32'h0);
    chk("t1_iv1", 32'(s_inst_v), 0);
    tick();
    chk("t1_ra2", s_req_a, 32'h4);
    chk("t1_iv2", 32'(s_inst_v), 0);
    tick();
    chk("t1_ra3", s_req_a, 32'h8);
    chk("t1_iv3", 32'(s_inst_v), 1);
    chk("t1_pc3", s_inst_pc, 32'h0);
    chk("t1_in3", s_inst, 32'hA5A5A5A5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_ivs", 32'(s_inst_v), 1);
      chk("t1_pcs", s_inst_pc, 32'(4 * i));
      chk("t1_ins", s_inst, 32'(4 * i) ^ K);
    end

    // credit limit with decode stalled
    do_reset();
    inst_ready = 1'b0;
    repeat (8) tick();
    chk("t2_nacc", 32'(nacc), 4);
    chk("t2_rv", 32'(s_req_v), 0);
    chk("t2_iv", 32'(s_inst_v), 1);
    chk("t2_pc", s_inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    chk("t2_pop", s_inst_pc, 32'h0);
    inst_ready = 1'b0;
    nacc = 0;
    repeat (4) tick();
    chk("t2_nacc1", 32'(nacc), 1);
    chk("t2_addr", last_a, 32'h10);
    inst_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_drain", s_inst_pc, 32'(4 * i));
    end

    // redirect with two stale fetches in flight
    do_reset();
    lat = 3;
    tick();
    tick();
    jmp_ctrl_signal = 1'b1;
    jump_address = 32'h100;
    tick();
    chk("t3_jrv", 32'(s_req_v), 0);
    chk("t3_jiv", 32'(s_inst_v), 0);
    jmp_ctrl_signal = 1'b0;
    tick();
    chk("t3_rv", 32'(s_req_v), 1);
    chk("t3_ra", s_req_a, 32'h100);
    chk("t3_iv0", 32'(s_inst_v), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stale", 32'(s_inst_v), 0);
    end
    tick();
    chk("t3_iv", 32'(s_inst_v), 1);
    chk("t3_pc", s_inst_pc, 32'h100);
    chk("t3_in", s_inst, 32'hA5A5A4A5);
    tick();
    chk("t3_pc2", s_inst_pc, 32'h104);
    chk("t3_in2", s_inst, 32'hA5A5A4A1);

    // response coincides with redirect
    do_reset();
    lat = 1;
    tick();
    jmp_ctrl_signal = 1'b1;
    jump_address = 32'h40;
    tick();
    chk("t4_iv", 32'(s_inst_v), 0);
    chk("t4_rv", 32'(s_req_v), 0);
    jmp_ctrl_signal = 1'b0;
    tick();
    chk("t4_rv2", 32'(s_req_v), 1);
    chk("t4_ra", s_req_a, 32'h40);
    chk("t4_iv2", 32'(s_inst_v), 0);
    tick();
    chk("t4_iv3", 32'(s_inst_v), 0);
    tick();
    chk("t4_iv4", 32'(s_inst_v), 1);
    chk("t4_pc", s_inst_pc, 32'h40);
    chk("t4_in", s_inst, 32'hA5A5A5E5);

    // random handshakes
    do_reset();
    lat = 1;
    rnd = 1'b1;
    ex = 32'h0;
    tbc = 0;
    maxc = 0;
    repeat (1000) begin
      tick();
      chk("t5_vld", 32'(s_inst_v), 32'(tbc != 0));
      if (s_inst_v && s_rdy) begin
        chk("t5_pc", s_inst_pc, ex);
        chk("t5_in", s_inst, ex ^ K);
        ex = ex + 32'h4;
      end
      tbc = tbc + int'(s_rsp) - int'(s_inst_v && s_rdy);
      if (tbc > maxc) maxc = tbc;
    end
    rnd = 1'b0;
    chk("t5_max", 32'(maxc <= 4), 1);
    chk("t5_prog", 32'(ex > 32'h100), 1);

    // reset mid-transfer
    do_reset();
    lat = 3;
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    mem_req_ready = 1'b0;
    tick();
    #1;
    chk("t6_prev", 32'(inst_valid), 1);
    do_reset();
    lat = 1;
    tick();
    chk("t6_rv", 32'(s_req_v), 1);
    chk("t6_ra", s_req_a, 32'h0);
    chk("t6_iv", 32'(s_inst_v), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction fetch stage with a decoupled memory request/response interface and an in-order prefetch queue. It holds the PC, issues sequential word fetches up to a credit limit, buffers returned instructions with their PCs, and hands them to decode over a valid/ready handshake. A redirect (jump) flushes the queue and discards responses still in flight from the old stream.

Parameters:
WORD_SIZE, 32, instruction/address width in bits
QUEUE_DEPTH, 4, prefetch queue entries; power of 2, >= 2; also the cap on queued plus outstanding fetches
RESET_PC, 0, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
jmp_ctrl_signal  input  1  redirect request from execute
jump_address  input  WORD_SIZE  redirect target
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  WORD_SIZE  fetch address (current PC)
mem_rsp_valid  input  1  response data valid; in order, no backpressure
mem_rsp_data  input  WORD_SIZE  fetched instruction word
inst_valid  output  1  queue head valid toward decode
inst_ready  input  1  decode accepts head
instruction_out  output  WORD_SIZE  queue head instruction
inst_pc  output  WORD_SIZE  PC of queue head

Behaviour:
- Reset is asynchronous. Reset values: pc = RESET_PC, rsp_pc = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0. Outputs at reset: mem_req_valid = 0, inst_valid = 0, instruction_out = 0, inst_pc = 0. Reset mid-transfer abandons all state, and responses to pre-reset requests are not tracked.
- Counters are $clog2(QUEUE_DEPTH+1) bits wide.
- Credit rule: mem_req_valid = !jmp_ctrl_signal && (count + outstanding < QUEUE_DEPTH). The queue therefore can never overflow, which is why the response path has no ready.
- mem_req_addr = pc. A request is accepted when mem_req_valid && mem_req_ready; on acceptance, pc += PC_STEP and outstanding++. pc wraps modulo 2^WORD_SIZE.
- Response handling (mem_rsp_valid): outstanding-- in all cases.
  - If drop_cnt > 0 or jmp_ctrl_signal = 1: discard the word; decrement drop_cnt if nonzero.
  - Otherwise: push {mem_rsp_data, rsp_pc} into the queue and advance rsp_pc += PC_STEP.
- Queue: circular buffer. A push is visible at the head the next cycle (no bypass). Push and pop in the same cycle leave count unchanged. instruction_out and inst_pc show the head entry; both are 0 when empty.
- inst_valid = (count != 0) && !jmp_ctrl_signal. A pop occurs on inst_valid && inst_ready.
- Redirect cycle (jmp_ctrl_signal = 1):
  - No request is issued and no pop occurs.
  - Next state: pc = rsp_pc = jump_address; queue emptied; drop_cnt = outstanding after this cycle's response decrement.
- Redirect takes priority over a simultaneous response or pop.
- Latency: with single-cycle memory and always-ready handshakes, the first request issues in the first cycle after reset release and inst_valid rises 2 cycles later. Sustained throughput is 1 instruction/cycle.
- jump_address is used verbatim; no alignment check.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output ports perf_flush_count (32 bits, counts redirect cycles) and perf_drop_count (32 bits, counts discarded responses). Both reset to 0 and saturate at all-ones.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, 1-cycle memory, always-ready, mem returns addr^0xA5A5A5A5 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; inst_pc 0x0 with inst_valid at cycle 3, then one instruction per cycle in order.
- inst_ready held 0, QUEUE_DEPTH=4 -> exactly 4 requests accepted, mem_req_valid low thereafter; queue holds PCs 0x0–0xC; one pop re-enables exactly 1 request (0x10).
- 3-cycle memory latency, 2 fetches outstanding, jump to 0x100 -> both stale responses dropped, drop_cnt reaches 0, first queued inst_pc = 0x100, no stale PC ever reaches decode.
- Response arrives in the same cycle as jump to 0x40 -> word discarded; inst_valid = 0 that cycle; next request address = 0x40.
- mem_req_ready toggling 1/0 randomly with inst_ready random for 1000 cycles -> inst_pc strictly sequential with step 4; count never exceeds 4.
- Reset asserted with 2 outstanding and queue non-empty -> all outputs return to reset values immediately; first post-reset request address = RESET_PC.
